// File: rtl/pcie_tl_pkg.sv
// Shared types and defaults for the transaction-layer VC scheduler.
package pcie_tl_pkg;

    localparam int NUM_VC   = 4;
    localparam int DATA_W   = 12;
    localparam int DEST_LSB = 8;

    localparam int W0_DEF = 4;
    localparam int W1_DEF = 3;
    localparam int W2_DEF = 2;
    localparam int W3_DEF = 1;

    typedef logic [1:0] vc_id_t;

    function automatic logic [NUM_VC-1:0] vc_onehot(input vc_id_t id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/wrr_grant_select.sv
// Combinational weighted round-robin grant decision for one cycle.
module wrr_grant_select
    import pcie_tl_pkg::*;
(
    input  vc_id_t            cur,
    input  logic [3:0]        cnt,
    input  logic [3:0]        eff_w,
    input  logic [NUM_VC-1:0] empty,
    input  logic              issue_ok,
    output logic              grant_valid,
    output vc_id_t            grant_id,
    output vc_id_t            next_cur,
    output logic [3:0]        next_cnt
);

    vc_id_t cand;

    // Stay on cur while it has credit; otherwise take the first non-empty VC
    // after cur, with cur itself last so an exhausted lone VC starts a new turn.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = cur;
        next_cur    = cur;
        next_cnt    = cnt;
        cand        = cur;
        if (issue_ok) begin
            if (!empty[cur] && (cnt < eff_w)) begin
                grant_valid = 1'b1;
                next_cnt    = cnt + 4'd1;
            end else begin
                for (int k = 1; k <= NUM_VC; k++) begin
                    cand = cur + vc_id_t'(k);
                    if (!grant_valid && !empty[cand]) begin
                        grant_valid = 1'b1;
                        grant_id    = cand;
                        next_cur    = cand;
                        next_cnt    = 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin scheduler from four VC input FIFOs to four class
// output FIFOs; pop is combinational, push/data_out land two cycles later.
module vc_wrr_scheduler
    import pcie_tl_pkg::*;
#(
    parameter int DATA_W   = pcie_tl_pkg::DATA_W,
    parameter int DEST_LSB = pcie_tl_pkg::DEST_LSB,
    parameter int W0       = W0_DEF,
    parameter int W1       = W1_DEF,
    parameter int W2       = W2_DEF,
    parameter int W3       = W3_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_VC-1:0] empty,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [DATA_W-1:0] data_in_3,
    input  logic [NUM_VC-1:0] almost_full,
    input  logic              qos_en,
    output logic [NUM_VC-1:0] pop,
    output logic [NUM_VC-1:0] push,
    output logic [DATA_W-1:0] data_out,
    output logic              idle
);

    if (W0 < 1 || W0 > 15 || W1 < 1 || W1 > 15 ||
        W2 < 1 || W2 > 15 || W3 < 1 || W3 > 15) begin : g_bad_weight
        $fatal(1, "vc_wrr_scheduler: every weight must be in 1..15");
    end

    vc_id_t            cur_q, cur_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              s1_vld_q, s1_vld_d;
    vc_id_t            s1_src_q, s1_src_d;
    logic [NUM_VC-1:0] push_q, push_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic              issue_ok;
    logic [3:0]        w_sel;
    logic [3:0]        eff_w;
    logic              grant_valid;
    vc_id_t            grant_id;
    vc_id_t            next_cur;
    logic [3:0]        next_cnt;
    logic [DATA_W-1:0] s1_word;

    // Reset in the gate keeps pop low for the whole reset pulse.
    assign issue_ok = ~reset & (almost_full == '0);

    // Weight of the current VC, flattened to 1 when QoS is off.
    always_comb begin
        case (cur_q)
            2'd0:    w_sel = 4'(W0);
            2'd1:    w_sel = 4'(W1);
            2'd2:    w_sel = 4'(W2);
            default: w_sel = 4'(W3);
        endcase
        eff_w = qos_en ? w_sel : 4'd1;
    end

    wrr_grant_select u_sel (
        .cur         (cur_q),
        .cnt         (cnt_q),
        .eff_w       (eff_w),
        .empty       (empty),
        .issue_ok    (issue_ok),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .next_cur    (next_cur),
        .next_cnt    (next_cnt)
    );

    // Read data of the VC popped last cycle.
    always_comb begin
        case (s1_src_q)
            2'd0:    s1_word = data_in_0;
            2'd1:    s1_word = data_in_1;
            2'd2:    s1_word = data_in_2;
            default: s1_word = data_in_3;
        endcase
    end

    // Next-state: arbitration state, stage-1 tag, stage-2 push/data.
    always_comb begin
        cur_d    = next_cur;
        cnt_d    = next_cnt;
        s1_vld_d = grant_valid;
        s1_src_d = grant_id;
        if (s1_vld_q) begin
            push_d     = vc_onehot(vc_id_t'(s1_word[DEST_LSB+1:DEST_LSB]));
            data_out_d = s1_word;
        end else begin
            push_d     = '0;
            data_out_d = data_out_q;
        end
    end

    // State registers; reset drops any in-flight word immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q      <= '0;
            cnt_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_src_q   <= '0;
            push_q     <= '0;
            data_out_q <= '0;
        end else begin
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            s1_vld_q   <= s1_vld_d;
            s1_src_q   <= s1_src_d;
            push_q     <= push_d;
            data_out_q <= data_out_d;
        end
    end

    assign pop      = grant_valid ? vc_onehot(grant_id) : '0;
    assign push     = push_q;
    assign data_out = data_out_q;
    assign idle     = ~s1_vld_q & ~(|push_q) & (&empty);

endmodule
